// File: rtl/wb_arb2_sdr.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port: alternating
// grant on ties, one dead cycle between owners, and a watchdog that aborts stalled accesses.
module wb_arb2_sdr #(
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int TMO_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              RESETN,
    input  logic              sdr_init_done,
    input  logic [TMO_W-1:0]  tmo_cfg_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [APP_AW-1:0] m0_addr_i,
    input  logic [dw-1:0]     m0_dat_i,
    input  logic [dw/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic [dw-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [APP_AW-1:0] m1_addr_i,
    input  logic [dw-1:0]     m1_dat_i,
    input  logic [dw/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic [dw-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [APP_AW-1:0] s_addr_o,
    output logic [dw-1:0]     s_dat_o,
    output logic [dw/8-1:0]   s_sel_o,
    output logic [2:0]        s_cti_o,
    input  logic [dw-1:0]     s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o,
    output logic [7:0]        tmo_cnt_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t           state_q;
    logic             last_q;
    logic             abrt_q;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic [7:0]       tmo_cnt_q;
    logic             gnt0, gnt1, tmo_hit;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = 3'b000;
        if (gnt0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_cti_o  = m0_cti_i;
        end else if (gnt1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_cti_o  = m1_cti_i;
        end
    end

    // An ack landing in the threshold cycle wins over the timeout.
    assign tmo_hit = (gnt0 | gnt1) && (tmo_cfg_i != '0) && (wdog_q == tmo_cfg_i) && !s_ack_i;

    assign m0_ack_o  = s_ack_i & gnt0 & m0_stb_i;
    assign m1_ack_o  = s_ack_i & gnt1 & m1_stb_i;
    assign m0_err_o  = gnt0 & tmo_hit;
    assign m1_err_o  = gnt1 & tmo_hit;
    assign m0_dat_o  = gnt0 ? s_dat_i : '0;
    assign m1_dat_o  = gnt1 ? s_dat_i : '0;
    assign gnt_o     = {gnt1, gnt0};
    assign tmo_cnt_o = tmo_cnt_q;

    always_comb begin
        if (s_ack_i || !s_stb_o) begin
            wdog_d = '0;
        end else if (wdog_q != '1) begin
            wdog_d = wdog_q + TMO_W'(1);
        end else begin
            wdog_d = wdog_q;
        end
    end

    // last_q starts at 1 so that master 0 wins the first tie after reset.
    always_ff @(posedge wb_clk_i or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            abrt_q    <= 1'b0;
            wdog_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            wdog_q <= wdog_d;
            if (tmo_hit && (tmo_cnt_q != 8'hFF)) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (sdr_init_done) begin
                        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                            state_q <= GNT0;
                            wdog_q  <= '0;
                        end else if (m1_cyc_i) begin
                            state_q <= GNT1;
                            wdog_q  <= '0;
                        end
                    end
                end
                GNT0: begin
                    if (tmo_hit) begin
                        state_q <= ABORT;
                        abrt_q  <= 1'b0;
                    end else if (!m0_cyc_i) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (tmo_hit) begin
                        state_q <= ABORT;
                        abrt_q  <= 1'b1;
                    end else if (!m1_cyc_i) begin
                        state_q <= IDLE;
                        last_q  <= 1'b1;
                    end
                end
                ABORT: begin
                    if (abrt_q ? !m1_cyc_i : !m0_cyc_i) begin
                        state_q <= IDLE;
                        last_q  <= abrt_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
